// File: rtl/mwb_pkg.sv
// Shared widths and lane payload layout for the Memory->Writeback stage.
package mwb_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned WB_W   = 3;
    localparam int unsigned REG_W  = 3;

    localparam int unsigned LANE_PAYLOAD_W = PC_W + WB_W + 3 * DATA_W + REG_W;

    typedef struct packed {
        logic [PC_W-1:0]   pc_plus1;
        logic [WB_W-1:0]   wb;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] zpad;
        logic [REG_W-1:0]  dest;
    } lane_payload_t;

    // Payload width of one lane for arbitrary field widths (same field order as lane_payload_t).
    function automatic int unsigned lane_payload_w(input int unsigned pc_w, input int unsigned wb_w,
                                                   input int unsigned data_w, input int unsigned reg_w);
        return pc_w + wb_w + 3 * data_w + reg_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; in_ready is a registered flag.
// main_clr clears bits of the held MAIN entry whenever MAIN is not being reloaded.
module pipe_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] main_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic             skid_full;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             emit;

    assign accept    = in_valid && !skid_full;
    assign emit      = main_valid && out_ready;
    assign in_ready  = !skid_full;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            main_valid <= 1'b0;
            skid_full  <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_full  <= 1'b0;
            main_data  <= main_data & ~main_clr;
        end else if (skid_full) begin
            // No accept is possible here; the only move is SKID -> MAIN on emit.
            if (emit) begin
                main_data <= skid_data;
                skid_full <= 1'b0;
            end else begin
                main_data <= main_data & ~main_clr;
            end
        end else if (accept) begin
            if (!main_valid || emit) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                skid_data <= in_data;
                skid_full <= 1'b1;
                main_data <= main_data & ~main_clr;
            end
        end else begin
            if (emit) begin
                main_valid <= 1'b0;
            end
            main_data <= main_data & ~main_clr;
        end
    end

endmodule

// File: rtl/mwb_pipe_stage.sv
// Memory->Writeback pipeline stage: LANES slots handshaked through a 2-entry skid buffer.
// Optional stall counter port/logic enabled by defining MWB_STALL_CNT_EN.
module mwb_pipe_stage #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned PC_W   = mwb_pkg::PC_W,
    parameter int unsigned DATA_W = mwb_pkg::DATA_W,
    parameter int unsigned WB_W   = mwb_pkg::WB_W,
    parameter int unsigned REG_W  = mwb_pkg::REG_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [LANES-1:0]         kill_lane,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_lane_vld,
    input  logic [LANES*PC_W-1:0]    in_pc_plus1,
    input  logic [LANES*WB_W-1:0]    in_wb,
    input  logic [LANES*DATA_W-1:0]  in_alu,
    input  logic [LANES*DATA_W-1:0]  in_mem,
    input  logic [LANES*DATA_W-1:0]  in_zpad,
    input  logic [LANES*REG_W-1:0]   in_dest,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_lane_vld,
    output logic [LANES*PC_W-1:0]    out_pc_plus1,
    output logic [LANES*WB_W-1:0]    out_wb,
    output logic [LANES*DATA_W-1:0]  out_alu,
    output logic [LANES*DATA_W-1:0]  out_mem,
    output logic [LANES*DATA_W-1:0]  out_zpad,
    output logic [LANES*REG_W-1:0]   out_dest
`ifdef MWB_STALL_CNT_EN
  , output logic [15:0]              stall_count
`endif
);

    import mwb_pkg::*;

    localparam int unsigned LANE_W   = lane_payload_w(PC_W, WB_W, DATA_W, REG_W);
    localparam int unsigned BODY_W   = LANES * LANE_W;
    localparam int unsigned WIDTH    = BODY_W + LANES;
    localparam int unsigned OFF_DEST = 0;
    localparam int unsigned OFF_ZPAD = OFF_DEST + REG_W;
    localparam int unsigned OFF_MEM  = OFF_ZPAD + DATA_W;
    localparam int unsigned OFF_ALU  = OFF_MEM + DATA_W;
    localparam int unsigned OFF_WB   = OFF_ALU + DATA_W;
    localparam int unsigned OFF_PC   = OFF_WB + WB_W;

    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] main_clr;

    // Lane valids sit above the lane payloads; flush also drops every lane valid of MAIN.
    assign in_data[BODY_W +: LANES] = in_lane_vld;
    assign out_lane_vld             = out_data[BODY_W +: LANES];
    assign main_clr                 = {kill_lane | {LANES{flush}}, {BODY_W{1'b0}}};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign in_data[i*LANE_W +: LANE_W] = {in_pc_plus1[i*PC_W +: PC_W],
                                              in_wb[i*WB_W +: WB_W],
                                              in_alu[i*DATA_W +: DATA_W],
                                              in_mem[i*DATA_W +: DATA_W],
                                              in_zpad[i*DATA_W +: DATA_W],
                                              in_dest[i*REG_W +: REG_W]};

        assign out_pc_plus1[i*PC_W +: PC_W] = out_data[i*LANE_W + OFF_PC +: PC_W];
        assign out_wb[i*WB_W +: WB_W]       = out_data[i*LANE_W + OFF_WB +: WB_W];
        assign out_alu[i*DATA_W +: DATA_W]  = out_data[i*LANE_W + OFF_ALU +: DATA_W];
        assign out_mem[i*DATA_W +: DATA_W]  = out_data[i*LANE_W + OFF_MEM +: DATA_W];
        assign out_zpad[i*DATA_W +: DATA_W] = out_data[i*LANE_W + OFF_ZPAD +: DATA_W];
        assign out_dest[i*REG_W +: REG_W]   = out_data[i*LANE_W + OFF_DEST +: REG_W];
    end

    pipe_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .main_clr  (main_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

`ifdef MWB_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where writeback holds off a presented bundle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule
